// File: rtl/rx_valid_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rx_valid_framer_if                                            |
// | Description : Bundle between the PHY receive tiles / link layer and the     |
// |               valid-lane framer.                                            |
// |               master : PHY side, drives rxval_din / rxdata_din and          |
// |                        observes the framed outputs.                         |
// |               slave  : framer side, consumes raw words and drives           |
// |                        out_data, out_valid, locked, offset, err_count.      |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface rx_valid_framer_if #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]       rxval_din;   // valid-lane word, LSB earliest UI
  logic [LANES*WIDTH-1:0] rxdata_din;  // lane i at [i*WIDTH +: WIDTH]
  logic [LANES*WIDTH-1:0] out_data;    // realigned words, same packing
  logic                   out_valid;   // out_data holds a framed word
  logic                   locked;      // framer is in LOCKED
  logic [2:0]             offset;      // alignment offset in UI
  logic [15:0]            err_count;   // saturating mismatch count while locked

  modport master (
    output rxval_din, rxdata_din,
    input  out_data, out_valid, locked, offset, err_count
  );

  modport slave (
    input  rxval_din, rxdata_din,
    output out_data, out_valid, locked, offset, err_count
  );
endinterface
`default_nettype wire

// File: rtl/rx_valid_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rx_valid_framer                                               |
// | Description : Finds the bit offset of the repeating 8'hf0 frame on the      |
// |               rxval lane, locks to it with hysteresis, and realigns every   |
// |               data lane to that offset with one cycle of latency.           |
// | Ports       : clk   - receive word clock (rising edge)                      |
// |               reset - synchronous, active-high                              |
// |               bus   - rx_valid_framer_if.slave (raw words in, framed out)   |
// | Option      : RX_FRAMER_ERR_COUNT_EN - when defined, err_count counts       |
// |               mismatch words while locked; otherwise it is tied to zero.    |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module rx_valid_framer #(
  parameter int LANES        = 16,
  parameter int WIDTH        = 32,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  rx_valid_framer_if.slave bus
);

  localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [WIDTH-1:0]  c_pat       = {(WIDTH/8){8'hf0}};
  localparam logic [CNT_W-1:0]  c_lock_last = CNT_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] c_miss_last = MISS_W'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MISS_W-1:0]      miss_q, miss_d;
  logic [2:0]             offset_q, offset_d;
  logic [WIDTH-1:0]       prev_val_q;
  logic [LANES*WIDTH-1:0] prev_data_q;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   locked_q, locked_d;

  logic [2*WIDTH-1:0]     w_win_val;
  logic [7:0]             w_match;
  logic                   w_match_off;
  logic [2:0]             w_hunt_off;
  logic [LANES*WIDTH-1:0] w_shift;

  // Previous word occupies the low half so that offset k selects UIs
  // starting k positions into the older word.
  assign w_win_val = {bus.rxval_din, prev_val_q};

  // The pattern repeats every 8 UI, so only offsets 0..7 are distinct.
  for (genvar k = 0; k < 8; k++) begin : g_match
    assign w_match[k] = (w_win_val[k +: WIDTH] == c_pat);
  end

  assign w_match_off = w_match[offset_q];

  // Lowest matching offset wins; at most one can match on a clean stream.
  always_comb begin
    w_hunt_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_match[k]) begin
        w_hunt_off = 3'(k);
      end
    end
  end

  // Each lane is shifted by the offset held before this edge.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [2*WIDTH-1:0] w_win;
    assign w_win = {bus.rxdata_din[i*WIDTH +: WIDTH], prev_data_q[i*WIDTH +: WIDTH]};
    assign w_shift[i*WIDTH +: WIDTH] = w_win[offset_q +: WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    offset_d = offset_q;
    case (state_q)
      HUNT: begin
        if (|w_match) begin
          offset_d = w_hunt_off;
          cnt_d    = CNT_W'(1);
          state_d  = VERIFY;
        end
      end
      VERIFY: begin
        if (w_match_off) begin
          if (cnt_q == c_lock_last) begin
            state_d = LOCKED;
            miss_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Offset is kept; only a fresh HUNT match may change it.
          state_d = HUNT;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (w_match_off) begin
          miss_d = '0;
        end else if (miss_q == c_miss_last) begin
          state_d = HUNT;
          miss_d  = '0;
        end else begin
          miss_d = miss_q + MISS_W'(1);
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
        miss_d  = '0;
      end
    endcase
  end

  always_comb begin
    out_data_d  = w_shift;
    out_valid_d = (state_q == LOCKED) && w_match_off;
    locked_d    = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      miss_q      <= '0;
      offset_q    <= '0;
      prev_val_q  <= '0;
      prev_data_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      offset_q    <= offset_d;
      prev_val_q  <= bus.rxval_din;
      prev_data_q <= bus.rxdata_din;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.locked    = locked_q;
  assign bus.offset    = offset_q;

`ifdef RX_FRAMER_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;
  logic        w_err_inc;

  assign w_err_inc = (state_q == LOCKED) && !w_match_off;

  always_comb begin
    err_count_d = err_count_q;
    if (w_err_inc && (err_count_q != 16'hffff)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 16'h0;
`endif

endmodule
`default_nettype wire
